dmem_ctrl: RTL and testbench

Data-memory responder for the RISC-V core. It accepts load/store requests issued by the core's execute stage, carries out RV32I byte/halfword/word accesses on a word-organised synchronous SRAM, and returns sign- or zero-extended load data with a one-cycle response strobe. Sub-word stores are done as read-modify-write. Malformed requests complete with an error flag and do not touch memory.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_sram.sv | 23 ++
 rtl/dmem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and
// the RV32I load/store funct3 codes.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } dmem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/dmem_sram.sv
// Word-organised synchronous single-port SRAM, 2**AW words of n bits.
// Read-first: a read in the same cycle as a write returns the old word.
// Contents are not reset.
module dmem_sram #(
  parameter int n  = 32,
  parameter int AW = 10
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [n-1:0]  wdata,
  output logic [n-1:0]  rdata
);

  logic [n-1:0] mem [2**AW];

  // Registered read of the addressed word, optional write of the same word.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: RV32I byte/halfword/word loads and stores on a
// word SRAM, sub-word stores as read-modify-write, one-cycle response strobe.
// Optional macro DMEM_MISALIGN_CHECK_EN turns misaligned halfword/word
// accesses into errors; otherwise the low address bits are ignored.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int n  = 32,
  parameter int AW = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_funct3,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [n-1:0] rsp_rdata,
  output logic         rsp_err
);

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MISALIGN_CHECK = 1'b1;
`else
  localparam bit MISALIGN_CHECK = 1'b0;
`endif

  dmem_state_t  state;
  logic         cap_we;
  logic [2:0]   cap_f3;
  logic [AW+1:0] cap_addr;
  logic [n-1:0] cap_wdata;

  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [n-1:0]  sram_wdata;
  logic [n-1:0]  rbuf;
  logic          accept;
  logic          req_bad;

  // Illegal funct3, plus misalignment when the check is compiled in.
  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [1:0] lane);
    logic bad;
    logic half;
    logic mis;
    if (we) bad = (f3 > F3_SW);
    else    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    half = we ? (f3 == F3_SH) : ((f3 == F3_LH) || (f3 == F3_LHU));
    mis  = (half && lane[0]) || ((f3 == F3_LW) && (lane != 2'b00));
    return bad || (MISALIGN_CHECK && mis);
  endfunction

  // Lane extraction with sign or zero extension.
  function automatic logic [n-1:0] load_extract(input logic [2:0] f3,
                                                input logic [1:0] lane,
                                                input logic [n-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [n-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      F3_LB:   r = {{(n-8){b[7]}}, b};
      F3_LBU:  r = {{(n-8){1'b0}}, b};
      F3_LH:   r = {{(n-16){h[15]}}, h};
      F3_LHU:  r = {{(n-16){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Store data merged into the word read back from the SRAM.
  function automatic logic [n-1:0] store_merge(input logic [2:0] f3,
                                               input logic [1:0] lane,
                                               input logic [n-1:0] word,
                                               input logic [n-1:0] wd);
    logic [n-1:0] r;
    r = word;
    case (f3)
      F3_SB:   r[{lane, 3'b000} +: 8] = wd[7:0];
      F3_SH:   r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign accept  = req_valid && req_ready;
  assign req_bad = req_error(req_we, req_funct3, req_addr[1:0]);

  // The read is launched at the acceptance edge from the live address so
  // the word is already in rbuf during RD; later cycles use the captured one.
  assign sram_addr  = (state == S_IDLE) ? req_addr[AW+1:2] : cap_addr[AW+1:2];
  assign sram_we    = (state == S_WR);
  assign sram_wdata = store_merge(cap_f3, cap_addr[1:0], rbuf, cap_wdata);

  dmem_sram #(.n(n), .AW(AW)) u_sram (
    .clock (clock),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (sram_wdata),
    .rdata (rbuf)
  );

  // Request capture; data path only, no reset needed.
  always_ff @(posedge clock) begin
    if (accept) begin
      cap_we    <= req_we;
      cap_f3    <= req_funct3;
      cap_addr  <= req_addr[AW+1:0];
      cap_wdata <= req_wdata;
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_bad) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we && (req_funct3 == F3_SW)) begin
              state <= S_WR;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (cap_we) begin
            state <= S_WR;
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_extract(cap_f3, cap_addr[1:0], rbuf);
          end
        end
        S_WR: begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl with a response scoreboard.
module tb_dmem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  dmem_ctrl #(.n(32), .AW(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd);
    int w;
    w = 0;
    @(negedge clock);
    while (!req_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clock);
    #1;
    req_valid  = 1'b0;
  endtask

  task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int elat);
    exp_t e;
    exp_t got;
    int lat;
    e.rdata = erd;
    e.err   = eerr;
    e.lat   = elat;
    sb_q.push_back(e);
    send(we, f3, addr, wd);
    @(negedge clock);
    lat = 1;
    check({tag, "_ready_low"}, {31'd0, req_ready}, 32'd0);
    while (!rsp_valid && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    got = sb_q.pop_front();
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_lat"}, lat, got.lat);
    check({tag, "_rdata"}, rsp_rdata, got.rdata);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, got.err});
    @(negedge clock);
    check({tag, "_strobe_once"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int seen;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset state
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_err",   {31'd0, rsp_err},   32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);

    // Word round trip
    issue("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    issue("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Byte merge
    issue("sw_20", 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0, 2);
    issue("sb_22", 1'b1, 3'b000, 32'h22, 32'h000000AA, 32'h0, 1'b0, 3);
    issue("lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11AA3344, 1'b0, 2);
    issue("sh_20", 1'b1, 3'b001, 32'h22, 32'h0000CAFE, 32'h0, 1'b0, 3);
    issue("lw_20b", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFE3344, 1'b0, 2);

    // Sign / zero extension
    issue("sw_30", 1'b1, 3'b010, 32'h30, 32'h8001FF80, 32'h0, 1'b0, 2);
    issue("lb_30",  1'b0, 3'b000, 32'h30, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    issue("lbu_30", 1'b0, 3'b100, 32'h30, 32'h0, 32'h00000080, 1'b0, 2);
    issue("lh_32",  1'b0, 3'b001, 32'h32, 32'h0, 32'hFFFF8001, 1'b0, 2);
    issue("lhu_32", 1'b0, 3'b101, 32'h32, 32'h0, 32'h00008001, 1'b0, 2);
    issue("lb_31",  1'b0, 3'b000, 32'h31, 32'h0, 32'hFFFFFFFF, 1'b0, 2);
    issue("lbu_33", 1'b0, 3'b100, 32'h33, 32'h0, 32'h00000080, 1'b0, 2);

    // Errors
    issue("sw_40", 1'b1, 3'b010, 32'h40, 32'h0BADF00D, 32'h0, 1'b0, 2);
`ifdef DMEM_MISALIGN_CHECK_EN
    issue("lw_41", 1'b0, 3'b010, 32'h41, 32'h0, 32'h0, 1'b1, 1);
`else
    issue("lw_41", 1'b0, 3'b010, 32'h41, 32'h0, 32'h0BADF00D, 1'b0, 2);
`endif
    issue("lw_40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0BADF00D, 1'b0, 2);
    issue("ld_f3_011", 1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 1);
    issue("ld_f3_110", 1'b0, 3'b110, 32'h40, 32'h0, 32'h0, 1'b1, 1);
    issue("st_f3_011", 1'b1, 3'b011, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    issue("lw_40_kept", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0BADF00D, 1'b0, 2);
    issue("sw_50", 1'b1, 3'b010, 32'h50, 32'h12345678, 32'h0, 1'b0, 2);
`ifdef DMEM_MISALIGN_CHECK_EN
    issue("sh_51", 1'b1, 3'b001, 32'h51, 32'h0000BEEF, 32'h0, 1'b1, 1);
    issue("lw_50", 1'b0, 3'b010, 32'h50, 32'h0, 32'h12345678, 1'b0, 2);
`else
    issue("sh_51", 1'b1, 3'b001, 32'h51, 32'h0000BEEF, 32'h0, 1'b0, 3);
    issue("lw_50", 1'b0, 3'b010, 32'h50, 32'h0, 32'h1234BEEF, 1'b0, 2);
`endif

    // Address wrap
    issue("sw_1000", 1'b1, 3'b010, 32'h1000, 32'h5, 32'h0, 1'b0, 2);
    issue("lw_0",    1'b0, 3'b010, 32'h0,    32'h0, 32'h5, 1'b0, 2);

    // Reset mid-RD: abandon the load, no response afterwards
    send(1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_rdata", rsp_rdata, 32'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (rsp_valid) seen++;
    end
    reset = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (rsp_valid) seen++;
    end
    check("mid_rst_no_rsp", seen, 0);
    check("mid_rst_ready2", {31'd0, req_ready}, 32'd1);
    issue("lw_10_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    check("sb_q_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
